// File: rtl/seq_shift_add_multiplier.sv
// Sequential add/subtract-and-shift multiplier: retires one multiplier bit per clock,
// signed (two's complement) or unsigned, with start/busy/done handshake and live A/B/X views.
module seq_shift_add_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     a_val,
    output logic [WIDTH-1:0]     b_val,
    output logic                 x_val
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned SUM_W = WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, m_q;
    logic               x_q, mode_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               load_c, step_c, last_c;
    logic [SUM_W-1:0]   ext_a_c, ext_m_c, sum_c, xa_c;
    logic [WIDTH-1:0]   a_shift_c, b_shift_c;

    assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

    // Add (or subtract on the signed sign-bit step), then shift {X,A,B} right by one.
    always_comb begin
        ext_a_c = {mode_q & a_q[WIDTH-1], a_q};
        ext_m_c = {mode_q & m_q[WIDTH-1], m_q};
        if (mode_q && last_c) begin
            sum_c = ext_a_c + ~ext_m_c + SUM_W'(1);
        end else begin
            sum_c = ext_a_c + ext_m_c;
        end
        xa_c      = b_q[0] ? sum_c : {x_q, a_q};
        a_shift_c = {xa_c[WIDTH], xa_c[WIDTH-1:1]};
        b_shift_c = {xa_c[0], b_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    load_c  = 1'b1;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (last_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, per-bit step and result/handshake registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            x_q     <= 1'b0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            busy <= (state_d == RUN);
            done <= step_c && last_c;
            if (load_c) begin
                m_q    <= multiplicand;
                b_q    <= multiplier;
                mode_q <= signed_mode;
                a_q    <= '0;
                x_q    <= 1'b0;
                cnt_q  <= '0;
            end else if (step_c) begin
                a_q   <= a_shift_c;
                b_q   <= b_shift_c;
                // Unsigned carry is consumed by the shift; signed keeps the sign bit.
                x_q   <= mode_q ? xa_c[WIDTH] : 1'b0;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_c) begin
                    product <= {a_shift_c, b_shift_c};
                end
            end
        end
    end

    assign a_val = a_q;
    assign b_val = b_q;
    assign x_val = x_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier at WIDTH 4, 8 and 16: vector table, handshake
// corner sequences and random operands, with a product scoreboard fed at start.
module tb_seq_shift_add_multiplier;

    logic Clk, Reset;

    logic s4_start, s4_sm, s4_busy, s4_done, s4_x;
    logic [3:0]  s4_mc, s4_mp, s4_a, s4_b;
    logic [7:0]  s4_prod;

    logic s8_start, s8_sm, s8_busy, s8_done, s8_x;
    logic [7:0]  s8_mc, s8_mp, s8_a, s8_b;
    logic [15:0] s8_prod;

    logic s16_start, s16_sm, s16_busy, s16_done, s16_x;
    logic [15:0] s16_mc, s16_mp, s16_a, s16_b;
    logic [31:0] s16_prod;

    seq_shift_add_multiplier #(.WIDTH(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .start(s4_start), .signed_mode(s4_sm),
        .multiplicand(s4_mc), .multiplier(s4_mp), .busy(s4_busy), .done(s4_done),
        .product(s4_prod), .a_val(s4_a), .b_val(s4_b), .x_val(s4_x));

    seq_shift_add_multiplier #(.WIDTH(8)) u_dut8 (
        .Clk(Clk), .Reset(Reset), .start(s8_start), .signed_mode(s8_sm),
        .multiplicand(s8_mc), .multiplier(s8_mp), .busy(s8_busy), .done(s8_done),
        .product(s8_prod), .a_val(s8_a), .b_val(s8_b), .x_val(s8_x));

    seq_shift_add_multiplier #(.WIDTH(16)) u_dut16 (
        .Clk(Clk), .Reset(Reset), .start(s16_start), .signed_mode(s16_sm),
        .multiplicand(s16_mc), .multiplier(s16_mp), .busy(s16_busy), .done(s16_done),
        .product(s16_prod), .a_val(s16_a), .b_val(s16_b), .x_val(s16_x));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          w;
        logic        sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[10];
    logic [63:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          sel = 8;
    string       cur_tag = "init";

    function automatic logic cur_done();
        case (sel)
            4:       return s4_done;
            8:       return s8_done;
            default: return s16_done;
        endcase
    endfunction

    function automatic logic cur_busy();
        case (sel)
            4:       return s4_busy;
            8:       return s8_busy;
            default: return s16_busy;
        endcase
    endfunction

    function automatic logic cur_x();
        case (sel)
            4:       return s4_x;
            8:       return s8_x;
            default: return s16_x;
        endcase
    endfunction

    function automatic logic [63:0] cur_prod();
        case (sel)
            4:       return 64'(s4_prod);
            8:       return 64'(s8_prod);
            default: return 64'(s16_prod);
        endcase
    endfunction

    function automatic logic [63:0] cur_ab();
        case (sel)
            4:       return 64'({s4_a, s4_b});
            8:       return 64'({s8_a, s8_b});
            default: return 64'({s16_a, s16_b});
        endcase
    endfunction

    function automatic logic [63:0] ref_mul(input int w, input logic sm,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(a & mask[31:0]);
        sb = longint'(b & mask[31:0]);
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic sm,
                         input logic [31:0] a, input logic [31:0] b);
        s4_start = 1'b0; s8_start = 1'b0; s16_start = 1'b0;
        case (w)
            4:       begin s4_start = st;  s4_sm = sm;  s4_mc = a[3:0];   s4_mp = b[3:0];   end
            8:       begin s8_start = st;  s8_sm = sm;  s8_mc = a[7:0];   s8_mp = b[7:0];   end
            default: begin s16_start = st; s16_sm = sm; s16_mc = a[15:0]; s16_mp = b[15:0]; end
        endcase
    endtask

    // Scoreboard: every done pops the oldest expected product.
    always @(negedge Clk) begin
        if (cur_done()) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s unexpected_done: got done=1, expected none", cur_tag);
            end else begin
                chk({cur_tag, " product"}, cur_prod(), exp_q.pop_front());
            end
        end
    end

    // Called just after a negedge; returns at the negedge where done is seen.
    task automatic run_op(input int w, input logic sm, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input string tag, input int mid);
        int lat;
        sel = w;
        cur_tag = tag;
        drive(w, 1'b1, sm, a, b);
        exp_q.push_back(exp);
        @(negedge Clk);
        drive(w, 1'b0, ~sm, ~a, ~b);
        chk({tag, " busy_high"}, 64'(cur_busy()), 64'd1);
        lat = 0;
        while (!cur_done() && lat < 3 * w) begin
            @(negedge Clk);
            lat++;
            if (lat == mid) drive(w, 1'b1, ~sm, 32'h5, 32'h3);
            else            drive(w, 1'b0, ~sm, ~a, ~b);
        end
        chk({tag, " latency"}, 64'(lat), 64'(w));
        chk({tag, " busy_low_at_done"}, 64'(cur_busy()), 64'd0);
        chk({tag, " ab_view"}, cur_ab(), exp);
        chk({tag, " x_view"}, 64'(cur_x()), sm ? 64'(exp[2*w-1]) : 64'd0);
        if (lat >= 3 * w) exp_q.delete();
    endtask

    task automatic settle();
        @(negedge Clk);
        chk({cur_tag, " done_one_cycle"}, 64'(cur_done()), 64'd0);
    endtask

    initial begin
        vecs[0] = '{8,  1'b1, 32'h07,   32'hFD,   64'hFFEB};
        vecs[1] = '{8,  1'b1, 32'h80,   32'h80,   64'h4000};
        vecs[2] = '{8,  1'b1, 32'hFF,   32'hFF,   64'h0001};
        vecs[3] = '{8,  1'b0, 32'hFF,   32'hFF,   64'hFE01};
        vecs[4] = '{4,  1'b1, 32'h8,    32'h7,    64'hC8};
        vecs[5] = '{4,  1'b0, 32'hF,    32'hF,    64'hE1};
        vecs[6] = '{4,  1'b1, 32'h0,    32'h5,    64'h00};
        vecs[7] = '{4,  1'b0, 32'h0,    32'hF,    64'h00};
        vecs[8] = '{16, 1'b1, 32'h8000, 32'h8000, 64'h4000_0000};
        vecs[9] = '{16, 1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE_0001};

        Reset = 1'b1;
        drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(8, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(16, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge Clk);
        sel = 8;
        chk("reset busy", 64'(cur_busy()), 64'd0);
        chk("reset done", 64'(cur_done()), 64'd0);
        chk("reset product", cur_prod(), 64'd0);
        chk("reset ab_view", cur_ab(), 64'd0);
        chk("reset x_view", 64'(cur_x()), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].w, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp,
                   $sformatf("vec%0d", i), 0);
            settle();
        end

        // Ignored start mid-operation, then a start accepted in the done cycle.
        run_op(8, 1'b1, 32'h07, 32'hFD, 64'hFFEB, "mid_start", 3);
        run_op(8, 1'b0, 32'h0C, 32'h0A, 64'h0078, "back_to_back", 0);
        settle();

        // Reset on the 4th RUN cycle aborts without a done pulse.
        cur_tag = "abort";
        drive(8, 1'b1, 1'b0, 32'h05, 32'h09);
        exp_q.push_back(64'd45);
        @(negedge Clk);
        drive(8, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        exp_q.delete();
        chk("abort busy", 64'(cur_busy()), 64'd0);
        chk("abort ab_view", cur_ab(), 64'd0);
        chk("abort x_view", 64'(cur_x()), 64'd0);
        chk("abort product", cur_prod(), 64'd0);
        chk("abort done", 64'(cur_done()), 64'd0);
        Reset = 1'b0;
        repeat (10) @(negedge Clk);
        run_op(8, 1'b0, 32'h2, 32'h3, 64'h6, "after_abort", 0);
        settle();

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 1000; i++) begin
                logic [31:0] ra, rb;
                ra = $urandom;
                rb = $urandom;
                run_op(8, m[0], ra, rb, ref_mul(8, m[0], ra, rb), "rand8", 0);
                settle();
            end
            for (int i = 0; i < 1000; i++) begin
                logic [31:0] ra, rb;
                ra = $urandom;
                rb = $urandom;
                run_op(16, m[0], ra, rb, ref_mul(16, m[0], ra, rb), "rand16", 0);
                settle();
            end
        end

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
